// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which pipeline stage owns the memory port
package mem_arb_pkg;

   localparam int unsigned MAX_D_STREAK_DEF = 4;
   localparam int unsigned TIMEOUT_DEF      = 255;
   localparam int unsigned STREAK_W         = 4;
   localparam int unsigned TO_W             = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant decision: data wins unless fetch has been starved
// for a full streak.
//   if_req, d_req : pending requests
//   streak_full   : data streak has reached its limit
//   grant_valid   : some requester is to be granted
//   owner         : which requester wins
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic   if_req,
   input  logic   d_req,
   input  logic   streak_full,
   output logic   grant_valid,
   output owner_t owner
);

   always_comb begin
      grant_valid = if_req | d_req;
      owner       = OWN_D;
      if (!d_req || (if_req && streak_full)) begin
         owner = OWN_I;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and the memory stage.
//   clk, rst                          : clock, async active-high reset
//   if_req/if_addr/if_done/if_rdata   : fetch read port
//   d_req/d_we/d_addr/d_wdata/d_done/d_rdata : data load/store port
//   stall_if, stall_mem               : stall requests to hazard logic
//   bus_err                           : pulse on timeout abort
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ready/mem_rdata : memory side
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW           = 32,
   parameter int unsigned DW           = 32,
   parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF,
   parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_done,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_done,
   output logic [DW-1:0] d_rdata,
   output logic          stall_if,
   output logic          stall_mem,
   output logic          bus_err,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_t          state, state_nxt;
   owner_t              grant_owner;
   logic                grant_valid, streak_full;
   logic                busy, to_hit, complete, arb_en, grant;
   logic [STREAK_W-1:0] streak;
   logic [TO_W-1:0]     to_cnt;
   logic                lat_we;
   logic [AW-1:0]       lat_addr;
   logic [DW-1:0]       lat_wdata;
   logic [DW-1:0]       if_rdata_q, d_rdata_q, cpl_rdata;

   // Abort fires in the TIMEOUT-th busy cycle without ready; a real
   // ready in that same cycle still completes normally.
   assign busy        = (state != IDLE);
   assign to_hit      = busy && !mem_ready && (to_cnt == TO_W'(TIMEOUT - 1));
   assign complete    = busy && (mem_ready || to_hit);
   assign arb_en      = !busy || complete;
   assign grant       = arb_en && grant_valid;
   assign streak_full = (streak == STREAK_W'(MAX_D_STREAK));
   assign cpl_rdata   = to_hit ? '0 : mem_rdata;

   arb_pick u_pick (
      .if_req      (if_req),
      .d_req       (d_req),
      .streak_full (streak_full),
      .grant_valid (grant_valid),
      .owner       (grant_owner)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: re-arbitrate when idle or on the completion cycle
   always_comb begin
      state_nxt = state;
      if (arb_en) begin
         if (!grant_valid)              state_nxt = IDLE;
         else if (grant_owner == OWN_D) state_nxt = BUSY_D;
         else                           state_nxt = BUSY_I;
      end
   end

   // Outputs: done/err/rdata are live in the completion cycle
   always_comb begin
      mem_req   = busy;
      mem_we    = (state == BUSY_D) && lat_we;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      if_done   = (state == BUSY_I) && complete;
      d_done    = (state == BUSY_D) && complete;
      bus_err   = to_hit;
      if_rdata  = if_done ? cpl_rdata : if_rdata_q;
      d_rdata   = d_done  ? cpl_rdata : d_rdata_q;
      stall_if  = if_req && !if_done;
      stall_mem = d_req  && !d_done;
   end

   // Grant latch, streak and timeout counters, held read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         streak     <= '0;
         to_cnt     <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if (grant) begin
            to_cnt <= '0;
            if (grant_owner == OWN_D) begin
               lat_we    <= d_we;
               lat_addr  <= d_addr;
               lat_wdata <= d_wdata;
            end else begin
               lat_we    <= 1'b0;
               lat_addr  <= if_addr;
               lat_wdata <= '0;
            end
            if (grant_owner == OWN_I || !if_req) streak <= '0;
            else if (!streak_full)               streak <= streak + STREAK_W'(1);
         end else if (busy && !mem_ready) begin
            to_cnt <= to_cnt + TO_W'(1);
         end
         if (if_done) if_rdata_q <= cpl_rdata;
         if (d_done)  d_rdata_q  <= cpl_rdata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_D_STREAK=4, TIMEOUT=8).
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we, mem_ready;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic        if_done, d_done, stall_if, stall_mem, bus_err;
   logic        mem_req, mem_we;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0] exp_order [10];

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .AW(32), .DW(32), .MAX_D_STREAK(4), .TIMEOUT(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_done   (if_done),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_done    (d_done),
      .d_rdata   (d_rdata),
      .stall_if  (stall_if),
      .stall_mem (stall_mem),
      .bus_err   (bus_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #5000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                    2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

      // Reset state
      #1 rst = 1'b1;
      #2;
      chk("rst_mem_req",  32'(mem_req), 32'd0);
      chk("rst_mem_we",   32'(mem_we),  32'd0);
      chk("rst_mem_addr", mem_addr,     32'd0);
      chk("rst_done",     32'({if_done, d_done, bus_err}), 32'd0);
      chk("rst_rdata",    if_rdata | d_rdata, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Single fetch, memory ready 2 cycles after mem_req
      drive_edge(); if_req = 1; if_addr = 32'h100;
      @(negedge clk);
      chk("f_req_lat0", 32'(mem_req), 32'd0);
      chk("f_stall0",   32'(stall_if), 32'd1);
      drive_edge();
      @(negedge clk);
      chk("f_mem_req",  32'(mem_req), 32'd1);
      chk("f_mem_addr", mem_addr, 32'h100);
      chk("f_mem_we",   32'(mem_we), 32'd0);
      drive_edge();
      @(negedge clk);
      chk("f_wait", 32'({if_done, stall_if}), 32'b01);
      drive_edge(); mem_ready = 1; mem_rdata = 32'h0050_0093;
      @(negedge clk);
      chk("f_done",  32'({if_done, stall_if}), 32'b10);
      chk("f_rdata", if_rdata, 32'h0050_0093);
      if_req = 0;
      drive_edge(); mem_ready = 0; mem_rdata = 32'h0;
      @(negedge clk);
      chk("f_idle",   32'({mem_req, if_done}), 32'b00);
      chk("f_hold",   if_rdata, 32'h0050_0093);

      // Store then back-to-back load
      drive_edge(); d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("st_stall", 32'({mem_req, stall_mem}), 32'b01);
      drive_edge(); mem_ready = 1;
      @(negedge clk);
      chk("st_we",    32'({mem_req, mem_we}), 32'b11);
      chk("st_addr",  mem_addr,  32'h2000);
      chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st_done",  32'({d_done, stall_mem}), 32'b10);
      d_we = 0;
      drive_edge(); mem_ready = 0; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("ld_b2b",  32'({mem_req, mem_we, d_done}), 32'b100);
      chk("ld_addr", mem_addr, 32'h2000);
      drive_edge(); mem_ready = 1;
      @(negedge clk);
      chk("ld_done",  32'(d_done), 32'd1);
      chk("ld_rdata", d_rdata, 32'hDEAD_BEEF);
      d_req = 0;
      drive_edge(); mem_ready = 0; mem_rdata = 32'h0;
      @(negedge clk);
      chk("ld_idle", 32'(mem_req), 32'd0);
      chk("ld_hold", d_rdata, 32'hDEAD_BEEF);

      // Contention with 1-cycle memory
      drive_edge(); if_req = 1; d_req = 1; if_addr = 32'h104; d_addr = 32'h3000; mem_ready = 1;
      @(negedge clk);
      chk("c_idle", 32'(mem_req), 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("c_grant%0d", i), 32'({if_done, d_done}), 32'(exp_order[i]));
      end
      if_req = 0; d_req = 0;
      drive_edge(); mem_ready = 0;

      // Timeout on data with fetch pending
      drive_edge(); d_req = 1; d_we = 0; d_addr = 32'h3000; if_req = 1; if_addr = 32'h108;
      mem_rdata = 32'hAAAA_5555;
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk($sformatf("to_wait%0d", i), 32'({mem_req, d_done, bus_err}), 32'b100);
      end
      @(negedge clk);
      chk("to_abort", 32'({d_done, bus_err, stall_mem}), 32'b110);
      chk("to_rdata", d_rdata, 32'h0);
      d_req = 0;
      drive_edge();
      @(negedge clk);
      chk("to_fetch", 32'({mem_req, bus_err, d_done}), 32'b100);
      chk("to_faddr", mem_addr, 32'h108);
      chk("to_dhold", d_rdata, 32'h0);
      drive_edge(); mem_ready = 1; mem_rdata = 32'h0000_0011;
      @(negedge clk);
      chk("to_fdone", 32'(if_done), 32'd1);
      if_req = 0;
      drive_edge(); mem_ready = 0;

      // Asynchronous reset in the middle of a store
      drive_edge(); d_req = 1; d_we = 1; d_addr = 32'h4000; d_wdata = 32'h1234_5678;
      drive_edge();
      @(negedge clk);
      chk("r_busy", 32'({mem_req, mem_we}), 32'b11);
      #2 rst = 1'b1; mem_ready = 1; d_req = 0;
      #1;
      chk("r_async",  32'({mem_req, mem_we, d_done, bus_err}), 32'b0000);
      chk("r_addr",   mem_addr, 32'h0);
      chk("r_rdata",  if_rdata | d_rdata, 32'h0);
      drive_edge(); rst = 1'b0; mem_ready = 0;
      @(negedge clk);
      chk("r_idle", 32'({mem_req, d_done}), 32'b00);

      // Fresh fetch after reset
      drive_edge(); if_req = 1; if_addr = 32'h100;
      @(negedge clk);
      chk("rf_lat0", 32'({mem_req, stall_if}), 32'b01);
      drive_edge();
      @(negedge clk);
      chk("rf_req", 32'({mem_req, mem_we}), 32'b10);
      chk("rf_addr", mem_addr, 32'h100);
      drive_edge();
      @(negedge clk);
      chk("rf_wait", 32'(if_done), 32'd0);
      drive_edge(); mem_ready = 1; mem_rdata = 32'h0050_0093;
      @(negedge clk);
      chk("rf_done",  32'(if_done), 32'd1);
      chk("rf_rdata", if_rdata, 32'h0050_0093);
      if_req = 0;
      drive_edge(); mem_ready = 0;

      // Ready pulse with no owner
      drive_edge(); mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("ri_none", 32'({if_done, d_done, bus_err, mem_req}), 32'b0000);
      drive_edge(); mem_ready = 0;
      @(negedge clk);
      chk("ri_state", 32'(mem_req), 32'd0);
      chk("ri_hold",  if_rdata, 32'h0050_0093);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
